// File: rtl/div_seq_32.sv
// Iterative 32-bit signed/unsigned divider: one shift-subtract per clock through a prop/gen adder.
// Optional macro DIV_SEQ_EARLY_OUT_EN: finish in 2 steps when the divisor is zero or exceeds the dividend.

module add_pg_32 (
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out
);
    logic [31:0] prop;
    logic [31:0] gen;
    logic [32:0] carry;

    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
        assign prop[gi] = val1[gi] ^ val2[gi];
        assign gen[gi]  = val1[gi] & val2[gi];
        assign sum[gi]  = prop[gi] ^ carry[gi];
    end

    always_comb begin
        carry[0] = carry_in;
        for (int i = 0; i < 32; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign carry_out = carry[32];
endmodule

module div_seq_32 #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
    logic [WIDTH-1:0] dvd_orig_q, dvd_orig_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] trial;
    logic             trial_cout;
    logic             no_borrow;

    // The shifted partial remainder is 33 bits wide; its top bit lives in rem_q[MSB].
    assign rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

    add_pg_32 u_sub (
        .val1      (rem_shift),
        .val2      (~dvs_mag_q),
        .carry_in  (1'b1),
        .sum       (trial),
        .carry_out (trial_cout)
    );

    assign no_borrow = rem_q[WIDTH-1] | trial_cout;
    assign dvd_neg   = is_signed & dividend[WIDTH-1];
    assign dvs_neg   = is_signed & divisor[WIDTH-1];

`ifdef DIV_SEQ_EARLY_OUT_EN
    logic early_out;
    // quo_q still holds |dividend| before the first shift.
    assign early_out = dbz_q | (dvs_mag_q > quo_q);
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_mag_d     = dvs_mag_q;
        dvd_orig_d    = dvd_orig_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    quo_d      = dvd_neg ? -dividend : dividend;
                    dvs_mag_d  = dvs_neg ? -divisor : divisor;
                    dvd_orig_d = dividend;
                    q_neg_d    = dvd_neg ^ dvs_neg;
                    r_neg_d    = dvd_neg;
                    dbz_d      = (divisor == '0);
                    rem_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
`ifdef DIV_SEQ_EARLY_OUT_EN
                if (cnt_q == '0 && early_out) begin
                    rem_d   = quo_q;
                    quo_d   = '0;
                    state_d = S_FIX;
                end else
`endif
                begin
                    rem_d = no_borrow ? trial : rem_shift;
                    quo_d = {quo_q[WIDTH-2:0], no_borrow};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                quotient_d    = dbz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
                remainder_d   = dbz_q ? dvd_orig_q : (r_neg_q ? -rem_q : rem_q);
                div_by_zero_d = dbz_q;
                state_d       = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_mag_q     <= '0;
            dvd_orig_q    <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_mag_q     <= dvs_mag_d;
            dvd_orig_q    <= dvd_orig_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dbz_q         <= dbz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_div_seq_32.sv
// Randomized + directed bench for div_seq_32; a queue-based scoreboard checks every done pulse
// against a 64-bit integer-arithmetic reference model.

module tb_div_seq_32;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    div_seq_32 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          done_cyc;
        int          busy_len;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain 64-bit integer division, truncating toward zero.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input int acc);
        exp_t   e;
        longint la, lb, ma, mb;
        bit     early;
        la = s ? longint'($signed(a)) : longint'({32'b0, a});
        lb = s ? longint'($signed(b)) : longint'({32'b0, b});
        ma = (la < 0) ? -la : la;
        mb = (lb < 0) ? -lb : lb;
        e.a = a; e.b = b; e.s = s;
        if (lb == 0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = 32'(la / lb);
            e.r = 32'(la % lb);
            e.z = 1'b0;
        end
        early = 1'b0;
`ifdef DIV_SEQ_EARLY_OUT_EN
        early = (lb == 0) || (mb > ma);
`endif
        e.done_cyc = acc + (early ? 2 : 33);
        e.busy_len = early ? 2 : 33;
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (busy) begin
            busy_cnt++;
        end else if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn a=%h b=%h s=%0d -> q=%h r=%h z=%0d at cycle %0d",
                         e.a, e.b, e.s, quotient, remainder, div_by_zero, cyc);
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", 32'(div_by_zero), 32'(e.z));
                check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                check("busy_len", 32'(busy_cnt), 32'(e.busy_len));
            end
            busy_cnt = 0;
        end else begin
            busy_cnt = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=%0d done=%0d want idle", busy, done);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int acc);
        wait_idle();
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        acc       = cyc + 1;
        sb.push_back(model(a, b, s, acc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got done=0 want done=1");
        end
        @(negedge clk);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        int acc;
        issue(a, b, s, acc);
        wait_done();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_quotient"}, quotient, 32'd0);
        check({tag, "_remainder"}, remainder, 32'd0);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        int acc;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_div(32'd100, 32'd7, 1'b0);
        run_div(32'hFFFF_FF9C, 32'd7, 1'b1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_div(32'd5, 32'd0, 1'b0);
        run_div(32'hFFFF_FFFB, 32'd0, 1'b1);
        run_div(32'd3, 32'd10, 1'b0);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_div(32'd100, 32'hFFFF_FFF9, 1'b1);

        // Starts while busy and in the done cycle must be ignored.
        issue(32'd1000, 32'd33, 1'b0, acc);
        for (int n = 0; n < 60 && !done; n++) begin
            if (cyc == acc + 5 || cyc == acc + 20) begin
                dividend = $urandom; divisor = 32'd3; is_signed = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (done) begin
            dividend = 32'd77; divisor = 32'd2; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_busy", 32'(busy), 32'd0);
        run_div(32'd77, 32'd2, 1'b0);

        // Reset in the middle of a run.
        issue(32'hFFFF_FFFF, 32'd3, 1'b0, acc);
        while (cyc < acc + 10) @(negedge clk);
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("midrst");
        repeat (40) @(negedge clk);
        run_div(32'hFFFF_FFFF, 32'd3, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            logic        s;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(1, 15));
                1: b = $urandom;
                2: b = a >> $urandom_range(0, 31);
                default: b = -32'($urandom_range(1, 9));
            endcase
            run_div(a, b, s);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
